// File: rtl/axis_to_axil_master.sv
// rtl/axis_to_axil_master.sv - stream-command driven AXI-lite initiator, one transaction in flight
// Commands on cmd_* become AXI-lite reads/writes on axil_*; results return on rsp_*.
module axis_to_axil_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEST_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter bit WRITE_ACK  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   cmd_tdata,
  input  logic [DEST_WIDTH-1:0]   cmd_tdest,
  input  logic [USER_WIDTH-1:0]   cmd_tuser,
  input  logic                    cmd_tvalid,
  output logic                    cmd_tready,
  output logic [DATA_WIDTH-1:0]   rsp_tdata,
  output logic [DEST_WIDTH-1:0]   rsp_tdest,
  output logic [USER_WIDTH-1:0]   rsp_tuser,
  output logic                    rsp_tvalid,
  output logic                    rsp_tlast,
  input  logic                    rsp_tready,
  output logic [ADDR_WIDTH-1:0]   axil_awaddr,
  output logic [2:0]              axil_awprot,
  output logic                    axil_awvalid,
  input  logic                    axil_awready,
  output logic [DATA_WIDTH-1:0]   axil_wdata,
  output logic [DATA_WIDTH/8-1:0] axil_wstrb,
  output logic                    axil_wvalid,
  input  logic                    axil_wready,
  input  logic [1:0]              axil_bresp,
  input  logic                    axil_bvalid,
  output logic                    axil_bready,
  output logic [ADDR_WIDTH-1:0]   axil_araddr,
  output logic [2:0]              axil_arprot,
  output logic                    axil_arvalid,
  input  logic                    axil_arready,
  input  logic [DATA_WIDTH-1:0]   axil_rdata,
  input  logic [1:0]              axil_rresp,
  input  logic                    axil_rvalid,
  output logic                    axil_rready,
  output logic                    busy,
  output logic                    bus_error,
  input  logic                    clear_error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    WR_RESP  = 3'd2,
    READ     = 3'd3,
    RD_DATA  = 3'd4,
    RESP_OUT = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [DEST_WIDTH-1:0]   rsp_dest_q, rsp_dest_d;
  logic [2:0]              rsp_user_q, rsp_user_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    bus_error_q, bus_error_d;

  // Only the read/write select bit of the command user field carries meaning.
  logic unused_cmd_user;
  assign unused_cmd_user = ^cmd_tuser[USER_WIDTH-1:1];

  assign cmd_tready   = reset && (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign bus_error    = bus_error_q;

  assign axil_awaddr  = awaddr_q;
  assign axil_awprot  = 3'b000;
  assign axil_awvalid = awvalid_q;
  assign axil_wdata   = wdata_q;
  assign axil_wstrb   = '1;
  assign axil_wvalid  = wvalid_q;
  assign axil_bready  = bready_q;
  assign axil_araddr  = araddr_q;
  assign axil_arprot  = 3'b000;
  assign axil_arvalid = arvalid_q;
  assign axil_rready  = rready_q;

  assign rsp_tdata    = rsp_data_q;
  assign rsp_tdest    = rsp_dest_q;
  assign rsp_tuser    = USER_WIDTH'(rsp_user_q);
  assign rsp_tvalid   = rsp_valid_q;
  assign rsp_tlast    = rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_data_d  = rsp_data_q;
    rsp_dest_d  = rsp_dest_q;
    rsp_user_d  = rsp_user_q;
    rsp_valid_d = rsp_valid_q;
    bus_error_d = bus_error_q;

    // Clear is applied first so a same-cycle error capture below overrides it.
    if (clear_error) begin
      bus_error_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_tvalid && cmd_tready) begin
          rsp_dest_d = cmd_tdest;
          if (cmd_tuser[0]) begin
            araddr_d  = cmd_tdest[ADDR_WIDTH-1:0];
            arvalid_d = 1'b1;
            state_d   = READ;
          end else begin
            awaddr_d  = cmd_tdest[ADDR_WIDTH-1:0];
            wdata_d   = cmd_tdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end
        end
      end

      WRITE: begin
        // AW and W retire independently; the phase ends once neither is pending.
        if (awvalid_q && axil_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && axil_wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bready_q && axil_bvalid) begin
          bready_d = 1'b0;
          if (axil_bresp != 2'b00) begin
            bus_error_d = 1'b1;
          end
          if (WRITE_ACK) begin
            rsp_data_d  = '0;
            rsp_user_d  = {1'b1, axil_bresp};
            rsp_valid_d = 1'b1;
            state_d     = RESP_OUT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      READ: begin
        if (arvalid_q && axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rready_q && axil_rvalid) begin
          rready_d    = 1'b0;
          rsp_data_d  = axil_rdata;
          rsp_user_d  = {1'b0, axil_rresp};
          rsp_valid_d = 1'b1;
          if (axil_rresp != 2'b00) begin
            bus_error_d = 1'b1;
          end
          state_d = RESP_OUT;
        end
      end

      RESP_OUT: begin
        if (rsp_tready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_dest_q  <= '0;
      rsp_user_q  <= '0;
      rsp_valid_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dest_q  <= rsp_dest_d;
      rsp_user_q  <= rsp_user_d;
      rsp_valid_q <= rsp_valid_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule
